// File: rtl/sum_window_serializer.sv
// Sums adder results over fixed windows of WIN_LEN valid samples and sends each window
// total off chip as a serial frame: a 1-cycle header carrying the window overflow flag,
// then the ACC_W-bit total, MSB first. One holding register sits between the
// accumulator and the shifter.
module sum_window_serializer #(
    parameter int unsigned SUM_W   = 5,
    parameter int unsigned ACC_W   = 12,
    parameter int unsigned WIN_LEN = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [SUM_W-1:0] sum_i,
    input  logic             sum_valid_i,
    output logic             ser_o,
    output logic             frame_o,
    output logic             busy_o,
    output logic             ovf_o,
    output logic             drop_o
);

    localparam int unsigned CNT_W = $clog2(WIN_LEN);
    localparam int unsigned BIT_W = $clog2(ACC_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ACC_W - 1);

    typedef enum logic [1:0] {StIdle, StHdr, StShift} state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wovf_q, wovf_d;
    logic [ACC_W-1:0] hold_q, hold_d;
    logic             hold_ovf_q, hold_ovf_d;
    logic             hold_full_q, hold_full_d;
    logic [ACC_W-1:0] sh_q, sh_d;
    logic             hbit_q, hbit_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             ser_d, frame_d, busy_d, ovf_d, drop_d;

    logic [ACC_W:0]   acc_sum;
    logic             clamp;
    logic [ACC_W-1:0] acc_sat;
    logic             win_close;
    logic             reload;
    logic             accept;

    // Saturating add of the zero-extended sample; window close and hold hand-off decode.
    always_comb begin
        acc_sum   = {1'b0, acc_q} + (ACC_W + 1)'(sum_i);
        clamp     = acc_sum[ACC_W];
        acc_sat   = clamp ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
        win_close = sum_valid_i && (cnt_q == CNT_LAST);
        // The shifter takes the held total when idle or on its last payload bit.
        reload    = hold_full_q &&
                    ((state_q == StIdle) || ((state_q == StShift) && (bit_q == '0)));
        // A closing window lands in hold only if hold is empty or being emptied now.
        accept    = win_close && (!hold_full_q || reload);
    end

    // Accumulator, window counter and holding register next state.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        wovf_d      = wovf_q;
        hold_d      = hold_q;
        hold_ovf_d  = hold_ovf_q;
        hold_full_d = hold_full_q;
        ovf_d       = ovf_o;
        drop_d      = win_close && hold_full_q && !reload;
        if (sum_valid_i) begin
            if (win_close) begin
                acc_d  = '0;
                cnt_d  = '0;
                wovf_d = 1'b0;
            end else begin
                acc_d  = acc_sat;
                cnt_d  = cnt_q + 1'b1;
                wovf_d = wovf_q | clamp;
            end
        end
        if (reload) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = acc_sat;
            hold_ovf_d  = wovf_q | clamp;
            hold_full_d = 1'b1;
            ovf_d       = ovf_o | wovf_q | clamp;
        end
    end

    // Frame FSM; outputs are registered from the current state, so they lag it by a cycle.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        hbit_d  = hbit_q;
        bit_d   = bit_q;
        ser_d   = 1'b0;
        frame_d = 1'b0;
        busy_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hold_full_q) begin
                    state_d = StHdr;
                end
            end
            StHdr: begin
                frame_d = 1'b1;
                busy_d  = 1'b1;
                ser_d   = hbit_q;
                bit_d   = BIT_LAST;
                state_d = StShift;
            end
            StShift: begin
                busy_d = 1'b1;
                ser_d  = sh_q[ACC_W-1];
                sh_d   = {sh_q[ACC_W-2:0], 1'b0};
                bit_d  = bit_q - 1'b1;
                if (bit_q == '0) begin
                    state_d = hold_full_q ? StHdr : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (reload) begin
            sh_d   = hold_q;
            hbit_d = hold_ovf_q;
        end
    end

    // Datapath state registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            wovf_q      <= 1'b0;
            hold_q      <= '0;
            hold_ovf_q  <= 1'b0;
            hold_full_q <= 1'b0;
            ovf_o       <= 1'b0;
            drop_o      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            wovf_q      <= wovf_d;
            hold_q      <= hold_d;
            hold_ovf_q  <= hold_ovf_d;
            hold_full_q <= hold_full_d;
            ovf_o       <= ovf_d;
            drop_o      <= drop_d;
        end
    end

    // FSM, shifter and serial output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= StIdle;
            sh_q    <= '0;
            hbit_q  <= 1'b0;
            bit_q   <= '0;
            ser_o   <= 1'b0;
            frame_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            hbit_q  <= hbit_d;
            bit_q   <= bit_d;
            ser_o   <= ser_d;
            frame_o <= frame_d;
            busy_o  <= busy_d;
        end
    end

endmodule

// File: tb/tb_sum_window_serializer.sv
// Bench for sum_window_serializer: three instances (default, ACC_W=8, WIN_LEN=4) driven by
// directed vectors; a frame monitor decodes the serial output and checks it against a
// queue of expected {header, payload} words.
module tb_sum_window_serializer;

    logic       clk;
    logic       rstb;
    logic [4:0] s     [3];
    logic       v     [3];
    logic       ser   [3];
    logic       frame [3];
    logic       busy  [3];
    logic       ovf   [3];
    logic       drop  [3];

    int total;
    int bad;

    logic [12:0] expq [3][$];
    logic [12:0] cur  [3];
    int          col  [3];

    int drops2, busy2, rises2;
    logic busy_prev2;

    sum_window_serializer u_def (
        .clk(clk), .rstb(rstb), .sum_i(s[0]), .sum_valid_i(v[0]), .ser_o(ser[0]),
        .frame_o(frame[0]), .busy_o(busy[0]), .ovf_o(ovf[0]), .drop_o(drop[0])
    );

    sum_window_serializer #(.SUM_W(5), .ACC_W(8), .WIN_LEN(16)) u_acc8 (
        .clk(clk), .rstb(rstb), .sum_i(s[1]), .sum_valid_i(v[1]), .ser_o(ser[1]),
        .frame_o(frame[1]), .busy_o(busy[1]), .ovf_o(ovf[1]), .drop_o(drop[1])
    );

    sum_window_serializer #(.SUM_W(5), .ACC_W(12), .WIN_LEN(4)) u_win4 (
        .clk(clk), .rstb(rstb), .sum_i(s[2]), .sum_valid_i(v[2]), .ser_o(ser[2]),
        .frame_o(frame[2]), .busy_o(busy[2]), .ovf_o(ovf[2]), .drop_o(drop[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    // Decode one cycle of serial output for instance id.
    task automatic mon_step(input int id, input logic rst, input logic fr, input logic sr);
        int accw;
        logic [12:0] e;
        accw = (id == 1) ? 8 : 12;
        if (!rst) begin
            col[id] = -1;
        end else if (col[id] >= 0) begin
            cur[id] = {cur[id][11:0], sr};
            col[id]++;
            if (col[id] == accw) begin
                col[id] = -1;
                total++;
                if (expq[id].size() == 0) begin
                    bad++;
                    $display("FAIL frame%0d unexpected got=%h want=none", id, cur[id]);
                end else begin
                    e = expq[id].pop_front();
                    if (cur[id] != e) begin
                        bad++;
                        $display("FAIL frame%0d got=%h want=%h", id, cur[id], e);
                    end
                end
            end
        end else if (fr) begin
            cur[id] = {12'b0, sr};
            col[id] = 0;
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) mon_step(i, rstb, frame[i], ser[i]);
    end

    // Drop pulses, busy cycles and busy rising edges of the WIN_LEN=4 instance.
    always @(negedge clk) begin
        if (drop[2]) drops2++;
        if (busy[2]) busy2++;
        if (busy[2] && !busy_prev2) rises2++;
        busy_prev2 = busy[2];
    end

    task automatic drv(input int id, input logic vv, input logic [4:0] ss);
        @(negedge clk);
        v[id] = vv;
        s[id] = ss;
    endtask

    initial begin
        int n, d0, b0, r0;
        total = 0; bad = 0;
        drops2 = 0; busy2 = 0; rises2 = 0; busy_prev2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b0; s[i] = '0; col[i] = -1; cur[i] = '0;
        end
        rstb = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_outs%0d", i), {ser[i], frame[i], busy[i], ovf[i], drop[i]}, 0);
        end
        rstb = 1'b1;

        // T1: 16 x 5 -> 0x050, header latency and 13-cycle busy
        expq[0].push_back(13'h050);
        for (int i = 0; i < 16; i++) drv(0, 1'b1, 5'd5);
        drv(0, 1'b0, 5'd0);
        chk("t1_frame_e0", frame[0], 0);
        @(negedge clk);
        chk("t1_frame_e1", frame[0], 0);
        @(negedge clk);
        chk("t1_frame_e2", frame[0], 1);
        n = 1;
        repeat (20) begin
            @(negedge clk);
            n += int'(busy[0]);
        end
        chk("t1_busy_len", n, 13);
        chk("t1_ovf", ovf[0], 0);

        // T2: alternating valid, invalid cycles carry 31 -> 0x030
        expq[0].push_back(13'h030);
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) drv(0, 1'b1, 5'd3);
            else drv(0, 1'b0, 5'd31);
        end
        drv(0, 1'b0, 5'd0);
        repeat (20) @(negedge clk);

        // T3: ACC_W=8, 16 x 31 saturates -> hdr 1, 0xFF; then 16 x 1 -> hdr 0, 0x10
        expq[1].push_back(13'h1FF);
        expq[1].push_back(13'h010);
        for (int i = 0; i < 32; i++) begin
            drv(1, 1'b1, (i < 16) ? 5'd31 : 5'd1);
            if (i == 16) chk("t3_ovf_set", ovf[1], 1);
        end
        drv(1, 1'b0, 5'd0);
        repeat (30) @(negedge clk);
        chk("t3_ovf_sticky", ovf[1], 1);

        // T4: WIN_LEN=4, 48 dense valids of 1 -> 5 frames of 0x004, 7 drops, one busy run
        d0 = drops2; b0 = busy2; r0 = rises2;
        for (int i = 0; i < 5; i++) expq[2].push_back(13'h004);
        for (int i = 0; i < 48; i++) drv(2, 1'b1, 5'd1);
        drv(2, 1'b0, 5'd0);
        repeat (40) @(negedge clk);
        chk("t4_drops", drops2 - d0, 7);
        chk("t4_busy_cycles", busy2 - b0, 65);
        chk("t4_busy_runs", rises2 - r0, 1);

        // T6: window C closes on frame B's last-bit reload edge -> 0x004, 0x008, 0x00C
        d0 = drops2; b0 = busy2; r0 = rises2;
        expq[2].push_back(13'h004);
        expq[2].push_back(13'h008);
        expq[2].push_back(13'h00C);
        for (int i = 0; i < 18; i++) begin
            if (i < 4) drv(2, 1'b1, 5'd1);
            else if (i < 6) drv(2, 1'b0, 5'd0);
            else if (i < 10) drv(2, 1'b1, 5'd2);
            else if (i < 14) drv(2, 1'b0, 5'd0);
            else drv(2, 1'b1, 5'd3);
        end
        drv(2, 1'b0, 5'd0);
        repeat (50) @(negedge clk);
        chk("t6_drops", drops2 - d0, 0);
        chk("t6_busy_cycles", busy2 - b0, 39);
        chk("t6_busy_runs", rises2 - r0, 1);

        // T5: reset during payload bit 5 with a partial window pending; frame is aborted
        for (int i = 0; i < 16; i++) drv(0, 1'b1, 5'd7);
        for (int i = 0; i < 5; i++) drv(0, 1'b1, 5'd9);
        drv(0, 1'b0, 5'd0);
        repeat (3) @(negedge clk);
        chk("t5_busy_mid", busy[0], 1);
        rstb = 1'b0;
        #1;
        chk("t5_async_clear", {ser[0], frame[0], busy[0]}, 0);
        @(negedge clk);
        #1 rstb = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            n += int'(busy[0]);
        end
        chk("t5_no_tail", n, 0);
        chk("t5_ovf_cleared", ovf[1], 0);
        expq[0].push_back(13'h020);
        for (int i = 0; i < 16; i++) drv(0, 1'b1, 5'd2);
        drv(0, 1'b0, 5'd0);

        n = 0;
        while (n < 100 && (expq[0].size() + expq[1].size() + expq[2].size()) != 0) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++) chk($sformatf("pending_frames%0d", i), expq[i].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
